// File: rtl/uart_rx.sv
// 8N1 / 8-bit-plus-parity UART receiver with mid-bit sampling and one-cycle valid strobe.
// Outputs hold until the next frame; a held-low line (break) yields a single errored frame.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int PARITY   = 0
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = (CPB - 1) / 2;
    localparam int TW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [TW-1:0] HALF_T = TW'(HALF);
    localparam logic [TW-1:0] LAST_T = TW'(CPB - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_d;
    logic [TW-1:0] timer;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic          perr;

    function automatic logic par_mismatch(input logic [7:0] d, input logic p);
        logic x;
        x = ^d ^ p;
        return (PARITY == 2) ? ~x : x;
    endfunction

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bitidx     <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a high-to-low transition arms, so a held break cannot retrigger.
                    if (rx_d && !rx_s) begin
                        state <= START;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_T) begin
                        timer <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= DATA;
                            bitidx <= '0;
                            perr   <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == LAST_T) begin
                        timer  <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitidx <= bitidx + 1'b1;
                        if (bitidx == 3'd7) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PAR: begin
                    if (timer == LAST_T) begin
                        timer <= '0;
                        perr  <= par_mismatch(shreg, rx_s);
                        state <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving mid stop bit lets an immediately following start edge be caught.
                    if (timer == LAST_T) begin
                        timer      <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        valid      <= 1'b1;
                        data       <= shreg;
                        frame_err  <= ~rx_s;
                        parity_err <= (PARITY != 0) && perr;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
